// File: rtl/perf_event_collector.sv
// Per-event counters with a snapshot-and-stream readout; define PERF_SATURATE_EN to saturate instead of wrap.
// First beat is valid the cycle after dump_req_i, one beat per cycle; out_ready_i low holds the current beat.
module perf_event_collector #(
  parameter int EVENT_NUM = 8,
  parameter int CNT_WIDTH = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [EVENT_NUM-1:0]         event_i,
  input  logic                         clear_i,
  input  logic                         dump_req_i,
  output logic                         dump_busy_o,
  output logic                         out_valid_o,
  input  logic                         out_ready_i,
  output logic [$clog2(EVENT_NUM)-1:0] out_id_o,
  output logic [CNT_WIDTH-1:0]         out_data_o,
  output logic                         out_last_o
);
  localparam int IDW = $clog2(EVENT_NUM);
  localparam logic [IDW-1:0] LAST_IDX = IDW'(EVENT_NUM - 1);

  typedef enum logic {IDLE, STREAM} state_t;

  state_t               state;
  state_t               state_nxt;
  logic [IDW-1:0]       idx;
  logic [CNT_WIDTH-1:0] live_cnt [EVENT_NUM];
  logic [CNT_WIDTH-1:0] snap_cnt [EVENT_NUM];
  logic                 start;
  logic                 beat_done;

  assign start     = (state == IDLE) && dump_req_i;
  assign beat_done = (state == STREAM) && out_ready_i;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (dump_req_i) state_nxt = STREAM;
      STREAM:  if (out_ready_i && (idx == LAST_IDX)) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx <= '0;
    end else if (start) begin
      idx <= '0;
    end else if (beat_done) begin
      idx <= (idx == LAST_IDX) ? '0 : idx + IDW'(1);
    end
  end

  // Non-blocking capture takes the pre-edge live values, so same-edge clear/events never leak in.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < EVENT_NUM; k++) snap_cnt[k] <= '0;
    end else if (start) begin
      for (int k = 0; k < EVENT_NUM; k++) snap_cnt[k] <= live_cnt[k];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < EVENT_NUM; k++) live_cnt[k] <= '0;
    end else begin
      for (int k = 0; k < EVENT_NUM; k++) begin
        if (clear_i) begin
          live_cnt[k] <= '0;
        end else if (event_i[k]) begin
`ifdef PERF_SATURATE_EN
          if (live_cnt[k] != '1) live_cnt[k] <= live_cnt[k] + CNT_WIDTH'(1);
`else
          live_cnt[k] <= live_cnt[k] + CNT_WIDTH'(1);
`endif
        end
      end
    end
  end

  // Valid/busy come straight off the state flop; ready only steers next state.
  assign out_valid_o = (state == STREAM);
  assign dump_busy_o = (state == STREAM);
  assign out_last_o  = (state == STREAM) && (idx == LAST_IDX);
  assign out_id_o    = idx;
  assign out_data_o  = snap_cnt[idx];

endmodule

// File: tb/tb_perf_event_collector.sv
// Directed bench for perf_event_collector (8 events, 8-bit counters) covering dump, stall, clear, wrap/saturate and reset abort.
module tb_perf_event_collector;
  localparam int EN = 8;
  localparam int CW = 8;

  logic          clk;
  logic          rst;
  logic [EN-1:0] event_i;
  logic          clear_i;
  logic          dump_req_i;
  logic          dump_busy_o;
  logic          out_valid_o;
  logic          out_ready_i;
  logic [2:0]    out_id_o;
  logic [CW-1:0] out_data_o;
  logic          out_last_o;

  logic [CW-1:0] exp_cnt [EN];
  int n_vec = 0;
  int n_err = 0;

  perf_event_collector #(.EVENT_NUM(EN), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .event_i(event_i), .clear_i(clear_i),
    .dump_req_i(dump_req_i), .dump_busy_o(dump_busy_o), .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i), .out_id_o(out_id_o), .out_data_o(out_data_o),
    .out_last_o(out_last_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic [EN-1:0] ev, input int n);
    event_i = ev;
    repeat (n) step();
    event_i = '0;
  endtask

  task automatic clr_exp();
    for (int i = 0; i < EN; i++) exp_cnt[i] = '0;
  endtask

  // Full dump against exp_cnt; optional stall, same-edge clear/event at request, events during stream, re-request at id 5.
  task automatic run_dump(input bit req_clr, input logic [EN-1:0] req_evt, input logic [EN-1:0] strm_evt,
                          input int stall_id, input int stall_n, input bit redump, input int exp_cycles);
    int beats, cycles, stalled;
    beats = 0; cycles = 0; stalled = 0;
    out_ready_i = 1'b1;
    dump_req_i  = 1'b1;
    clear_i     = req_clr;
    event_i     = req_evt;
    step();
    dump_req_i = 1'b0;
    clear_i    = 1'b0;
    event_i    = '0;
    chk("req_busy", dump_busy_o, 1);
    while (dump_busy_o && cycles < 64) begin
      chk("beat_valid", out_valid_o, 1);
      chk("beat_id", out_id_o, beats);
      chk("beat_data", out_data_o, exp_cnt[beats & 7]);
      chk("beat_last", out_last_o, beats == 7);
      if (beats == stall_id && stalled < stall_n) begin
        out_ready_i = 1'b0;
        stalled++;
      end else begin
        out_ready_i = 1'b1;
      end
      dump_req_i = redump && (beats == 5);
      event_i    = strm_evt;
      step();
      if (out_ready_i) beats++;
      cycles++;
    end
    dump_req_i  = 1'b0;
    event_i     = '0;
    out_ready_i = 1'b1;
    chk("dump_cycles", cycles, exp_cycles);
    chk("dump_beats", beats, 8);
    chk("end_valid", out_valid_o, 0);
  endtask

  initial begin
    rst = 1'b1; event_i = '0; clear_i = 1'b0; dump_req_i = 1'b0; out_ready_i = 1'b1;
    #2 rst = 1'b0;
    #1;
    chk("rst_valid", out_valid_o, 0);
    chk("rst_busy", dump_busy_o, 0);
    chk("rst_last", out_last_o, 0);
    chk("rst_id", out_id_o, 0);
    chk("rst_data", out_data_o, 0);
    step(); step();
    rst = 1'b1;
    step();

    // event 3 five times, plain dump
    pulse(8'h08, 5);
    clr_exp();
    exp_cnt[3] = 8'd5;
    run_dump(1'b0, '0, '0, -1, 0, 1'b0, 8);

    // 4-cycle stall at id 2
    run_dump(1'b0, '0, '0, 2, 4, 1'b0, 12);

    // re-request at id 5 ignored; event 6 counts during the stream
    run_dump(1'b0, '0, 8'h40, -1, 0, 1'b1, 8);
    step();
    chk("redump_idle", dump_busy_o, 0);
    exp_cnt[6] = 8'd8;
    run_dump(1'b0, '0, '0, -1, 0, 1'b0, 8);

    // clear + event 0 + dump on the same edge with counter0 = 9
    pulse(8'h01, 9);
    exp_cnt[0] = 8'd9;
    run_dump(1'b1, 8'h01, '0, -1, 0, 1'b0, 8);
    clr_exp();
    run_dump(1'b0, '0, '0, -1, 0, 1'b0, 8);

    // counter1 to all-ones, then one more event
    pulse(8'h02, 255);
    exp_cnt[1] = 8'd255;
    run_dump(1'b0, '0, '0, -1, 0, 1'b0, 8);
    pulse(8'h02, 1);
`ifdef PERF_SATURATE_EN
    exp_cnt[1] = 8'd255;
`else
    exp_cnt[1] = 8'd0;
`endif
    run_dump(1'b0, '0, '0, -1, 0, 1'b0, 8);

    // reset during beat id 4
    pulse(8'h10, 3);
    dump_req_i = 1'b1;
    step();
    dump_req_i  = 1'b0;
    out_ready_i = 1'b1;
    repeat (4) step();
    chk("abort_id", out_id_o, 4);
    chk("abort_data", out_data_o, 3);
    rst = 1'b0;
    #1;
    chk("abort_valid", out_valid_o, 0);
    chk("abort_busy", dump_busy_o, 0);
    chk("abort_last", out_last_o, 0);
    chk("abort_out_id", out_id_o, 0);
    chk("abort_out_data", out_data_o, 0);
    step(); step();
    chk("rst_hold_valid", out_valid_o, 0);
    rst = 1'b1;
    step();
    chk("post_rst_busy", dump_busy_o, 0);
    chk("post_rst_valid", out_valid_o, 0);
    clr_exp();
    run_dump(1'b0, '0, '0, -1, 0, 1'b0, 8);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
